reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port integer register file, the next generation of the core register file.
- Configurable read-port count, write-port count, depth and width.
- Selectable synchronous or asynchronous read, and optional write-to-read bypass.
- Per-register busy scoreboard, so issue logic can detect pending writebacks.
- Sits between decode (read ports, busy query) and writeback (write ports).

Parameters:
WIDTH, 32, data width in bits
DEPTH, 32, number of architectural registers; must satisfy DEPTH <= 2**ADDR_W
ADDR_W, 5, register address width
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
SYNC_READ, 1, 1 = registered read with 1-cycle latency; 0 = combinational read
BYPASS, 1, 1 = same-cycle write data is forwarded to reads of the same address
ZERO_REG, 1, 1 = register 0 is hardwired to zero, never written and never busy

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*WIDTH  read data; port p occupies bits [p*WIDTH +: WIDTH]
rd_busy  out  NUM_RD  busy bit of the addressed register; same timing as rd_data
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  write addresses
wr_data  in  NUM_WR*WIDTH  write data
busy_set_en  in  1  mark a register as having a pending write
busy_set_addr  in  ADDR_W  register to mark busy

Behaviour:
Reset:
- While rst is high at a clock edge, all DEPTH registers go to 0 and all busy bits go to 0.
- In SYNC_READ=1 mode, rd_data and rd_busy also go to 0.
- Reset overrides every write and busy-set in the same cycle.
- Reset asserted mid-operation discards all pending writes; the first read after reset returns 0.

Write:
- At the edge, for each port w with wr_en[w]=1, mem[wr_addr[w]] <= wr_data[w].
- If two write ports target the same address in one cycle, the higher-index port wins.
- A write to address 0 when ZERO_REG=1 is ignored.
- A write to an address >= DEPTH is ignored.

Read, SYNC_READ=1:
- At the edge, for each port p with rd_en[p]=1, rd_data[p] is updated with the value of mem[rd_addr[p]].
- rd_busy[p] is updated with the busy bit of the same register.
- Latency is 1 cycle.
- When rd_en[p]=0, rd_data[p] and rd_busy[p] hold their previous values.

Read, SYNC_READ=0:
- rd_data and rd_busy are combinational functions of rd_addr.
- rd_en is ignored.

Bypass:
- BYPASS=1: if a read and an enabled write hit the same valid address in the same cycle, the read returns wr_data (winning port) and rd_busy=0.
- BYPASS=0: the read returns the old mem value and the old busy bit.

Read address rules:
- Address 0 with ZERO_REG=1 always reads 0 with busy=0.
- An address >= DEPTH reads 0 with busy=0.

Scoreboard:
- busy[a] is cleared at the edge by any accepted write to a.
- busy[a] is set at the edge by busy_set_en with busy_set_addr=a.
- If a set and a clear hit the same address in one cycle, set wins and busy stays 1 (a new producer was issued).
- busy_set_addr=0 with ZERO_REG=1, or busy_set_addr >= DEPTH, is ignored.

Read ports are fully independent:
- Any number of ports may read the same address in the same cycle.

Test Plan:
1. Reset, default params: assert rst 2 cycles, then read r1..r31 on both ports -> all rd_data=0, rd_busy=0, 1-cycle latency.
2. Write r5=0xDEADBEEF; next cycle rd_en port0 addr 5 -> rd_data[0]=0xDEADBEEF one cycle after the read. Write r0=0x1234, then read r0 -> 0.
3. Bypass: in the same cycle, write r7=0xA5A5A5A5 and read r7 on port1. BYPASS=1 -> 0xA5A5A5A5. Rebuild with BYPASS=0, r7 previously 0x11 -> 0x11.
4. NUM_WR=2: both ports write r9, port0=0x1, port1=0x2 -> subsequent read r9=0x2. Different addresses in the same cycle -> both values retained.
5. Scoreboard sequence:
   - busy_set r12 -> next read r12 shows busy=1.
   - Write r12 alone -> busy cleared.
   - busy_set r12 together with a write to r12 in the same cycle -> busy=1 and data updated.
6. Reset mid-operation: r3=0x55 and busy[3]=1; assert rst together with wr_en r3=0x66 -> after reset, r3 reads 0, busy=0. SYNC_READ=0 build: changing rd_addr changes rd_data in the same cycle with rd_en=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with optional registered read, write-to-read
// bypass, hardwired zero register and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned NUM_WR    = 1,
  parameter int unsigned SYNC_READ = 1,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data,
  input  logic                     busy_set_en,
  input  logic [ADDR_W-1:0]        busy_set_addr
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [WIDTH-1:0]  wd [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic              set_ok;

  logic [WIDTH-1:0]  rd_val [NUM_RD];
  logic [NUM_RD-1:0] rd_bsy;

  // Architecturally writable/readable: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) ra[p] = rd_addr[p*ADDR_W +: ADDR_W];
    for (int w = 0; w < NUM_WR; w++) begin
      wa[w]    = wr_addr[w*ADDR_W +: ADDR_W];
      wd[w]    = wr_data[w*WIDTH +: WIDTH];
      wr_ok[w] = wr_en[w] && addr_ok(wa[w]);
    end
    set_ok = busy_set_en && addr_ok(busy_set_addr);
  end

  // Ascending port order lets the higher-index write win; the busy set is applied last
  // so a newly issued producer overrides a same-cycle writeback clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_ok[w]) begin
        mem_d[wa[w]]  = wd[w];
        busy_d[wa[w]] = 1'b0;
      end
    end
    if (set_ok) busy_d[busy_set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val[p] = '0;
      rd_bsy[p] = 1'b0;
      if (addr_ok(ra[p])) begin
        rd_val[p] = mem_q[ra[p]];
        rd_bsy[p] = busy_q[ra[p]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w] && (wa[w] == ra[p])) begin
              rd_val[p] = wd[w];
              rd_bsy[p] = 1'b0;
            end
          end
        end
      end
    end
  end

  if (SYNC_READ != 0) begin : g_sync
    logic [NUM_RD*WIDTH-1:0] rd_data_q;
    logic [NUM_RD-1:0]       rd_busy_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q <= '0;
        rd_busy_q <= '0;
      end else begin
        for (int p = 0; p < NUM_RD; p++) begin
          if (rd_en[p]) begin
            rd_data_q[p*WIDTH +: WIDTH] <= rd_val[p];
            rd_busy_q[p]                <= rd_bsy[p];
          end
        end
      end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;
  end else begin : g_async
    logic unused_rd_en;
    assign unused_rd_en = ^rd_en;

    always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_RD; p++) rd_data[p*WIDTH +: WIDTH] = rd_val[p];
    end
    assign rd_busy = rd_bsy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: a default-parameter instance driven from a vector table plus
// hand sequences, and an async/no-bypass/dual-write instance with DEPTH=20.
module tb_reg_file_mp;

  logic clk;
  logic rst;

  // Instance A: default parameters (sync read, bypass, one write port).
  logic [1:0]  a_rd_en;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [0:0]  a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_bs_en;
  logic [4:0]  a_bs_addr;

  // Instance B: async read, no bypass, two write ports, DEPTH=20.
  logic [1:0]  b_rd_en;
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [63:0] b_wr_data;
  logic        b_bs_en;
  logic [4:0]  b_bs_addr;

  int pass_cnt = 0;
  int total_cnt = 0;

  reg_file_mp dut_a (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (a_rd_en),
    .rd_addr      (a_rd_addr),
    .rd_data      (a_rd_data),
    .rd_busy      (a_rd_busy),
    .wr_en        (a_wr_en),
    .wr_addr      (a_wr_addr),
    .wr_data      (a_wr_data),
    .busy_set_en  (a_bs_en),
    .busy_set_addr(a_bs_addr)
  );

  reg_file_mp #(
    .DEPTH    (20),
    .NUM_WR   (2),
    .SYNC_READ(0),
    .BYPASS   (0)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (b_rd_en),
    .rd_addr      (b_rd_addr),
    .rd_data      (b_rd_data),
    .rd_busy      (b_rd_busy),
    .wr_en        (b_wr_en),
    .wr_addr      (b_wr_addr),
    .wr_data      (b_wr_data),
    .busy_set_en  (b_bs_en),
    .busy_set_addr(b_bs_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        bs;
    logic [4:0]  ba;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;  // {port1, port0}
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic bs, input logic [4:0] ba, input logic [1:0] re,
                         input logic [4:0] r0, input logic [4:0] r1);
    a_wr_en   = we;
    a_wr_addr = wa;
    a_wr_data = wd;
    a_bs_en   = bs;
    a_bs_addr = ba;
    a_rd_en   = re;
    a_rd_addr = {r1, r0};
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd1,  5'd31,
                 32'h0,        32'h0,        2'b00};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  2'b11, 5'd1,  5'd2,
                 32'h0,        32'h0,        2'b00};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd5,  5'd0,
                 32'hDEADBEEF, 32'h0,        2'b00};
    vecs[3]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  2'b00, 5'd0,  5'd0,
                 32'hDEADBEEF, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd0,  5'd5,
                 32'h0,        32'hDEADBEEF, 2'b00};
    vecs[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  2'b11, 5'd5,  5'd7,
                 32'hDEADBEEF, 32'hA5A5A5A5, 2'b00};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 2'b11, 5'd12, 5'd7,
                 32'h0,        32'hA5A5A5A5, 2'b00};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd12, 5'd12,
                 32'h0,        32'h0,        2'b11};
    vecs[8]  = '{1'b1, 5'd12, 32'hCAFE,     1'b0, 5'd0,  2'b01, 5'd12, 5'd0,
                 32'hCAFE,     32'h0,        2'b10};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd12, 5'd12,
                 32'hCAFE,     32'hCAFE,     2'b00};
    vecs[10] = '{1'b1, 5'd12, 32'hBEEF,     1'b1, 5'd12, 2'b00, 5'd0,  5'd0,
                 32'hCAFE,     32'hCAFE,     2'b00};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd12, 5'd0,
                 32'hBEEF,     32'h0,        2'b01};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  2'b11, 5'd0,  5'd12,
                 32'h0,        32'hBEEF,     2'b10};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd0,  5'd5,
                 32'h0,        32'hDEADBEEF, 2'b00};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd31, 5'd12,
                 32'h0,        32'hBEEF,     2'b10};
    vecs[15] = '{1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,  2'b01, 5'd0,  5'd0,
                 32'h0,        32'hBEEF,     2'b10};

    rst = 1'b1;
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
    b_rd_en   = 2'b00;
    b_rd_addr = '0;
    b_wr_en   = 2'b00;
    b_wr_addr = '0;
    b_wr_data = '0;
    b_bs_en   = 1'b0;
    b_bs_addr = '0;

    repeat (2) step();
    rst = 1'b0;
    check("a_reset_data", a_rd_data, 64'h0);
    check("a_reset_busy", {62'h0, a_rd_busy}, 64'h0);

    // Every register reads zero and idle after reset.
    for (int a = 1; a < 32; a++) begin
      drive_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'(a), 5'(32 - a));
      step();
      check($sformatf("a_post_reset_r%0d", a), {a_rd_busy, a_rd_data}, 66'h0);
    end

    for (int i = 0; i < 16; i++) begin
      drive_a(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].bs, vecs[i].ba, vecs[i].re,
              vecs[i].ra0, vecs[i].ra1);
      step();
      check($sformatf("a_vec%0d_data", i), a_rd_data, {vecs[i].d1, vecs[i].d0});
      check($sformatf("a_vec%0d_busy", i), {62'h0, a_rd_busy}, {62'h0, vecs[i].busy});
    end

    // Reset in mid-operation discards a same-cycle write and busy set.
    drive_a(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
    step();
    drive_a(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 2'b00, 5'd0, 5'd0);
    step();
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b01, 5'd3, 5'd0);
    step();
    check("a_r3_pre_reset", {31'h0, a_rd_busy[0], a_rd_data[31:0]}, {31'h0, 1'b1, 32'h55});
    rst = 1'b1;
    drive_a(1'b1, 5'd3, 32'h66, 1'b1, 5'd3, 2'b11, 5'd3, 5'd3);
    step();
    check("a_out_in_reset", {a_rd_busy, a_rd_data}, 66'h0);
    rst = 1'b0;
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd3, 5'd5);
    step();
    check("a_r3_after_reset", {a_rd_busy[0], a_rd_data[31:0]}, 33'h0);
    check("a_r5_after_reset", {a_rd_busy[1], a_rd_data[63:32]}, 33'h0);

    // Instance B: rd_en stays low throughout; reads are combinational.
    b_rd_addr = {5'd0, 5'd3};
    #1;
    check("b_reset_r3", {b_rd_busy, b_rd_data}, 66'h0);

    b_wr_en   = 2'b11;
    b_wr_addr = {5'd9, 5'd9};
    b_wr_data = {32'h2, 32'h1};
    step();
    b_wr_en   = 2'b00;
    b_rd_addr = {5'd0, 5'd9};
    #1;
    check("b_same_addr_port1_wins", {32'h0, b_rd_data[31:0]}, 64'h2);

    b_wr_en   = 2'b11;
    b_wr_addr = {5'd6, 5'd4};
    b_wr_data = {32'h66, 32'h44};
    step();
    b_wr_en   = 2'b00;
    b_rd_addr = {5'd6, 5'd4};
    #1;
    check("b_dual_write", b_rd_data, {32'h66, 32'h44});

    b_wr_en   = 2'b01;
    b_wr_addr = {5'd0, 5'd7};
    b_wr_data = {32'h0, 32'h11};
    step();
    b_wr_data = {32'h0, 32'hA5A5A5A5};
    b_rd_addr = {5'd7, 5'd4};
    #1;
    check("b_no_bypass_old", {32'h0, b_rd_data[63:32]}, 64'h11);
    step();
    b_wr_en = 2'b00;
    #1;
    check("b_r7_new", {32'h0, b_rd_data[63:32]}, 64'hA5A5A5A5);

    b_rd_addr = {5'd0, 5'd4};
    #1;
    check("b_async_r4", {32'h0, b_rd_data[31:0]}, 64'h44);
    b_rd_addr = {5'd0, 5'd6};
    #1;
    check("b_async_r6", {32'h0, b_rd_data[31:0]}, 64'h66);

    // Out-of-range write and busy set are ignored; the last valid register works.
    b_wr_en   = 2'b11;
    b_wr_addr = {5'd25, 5'd19};
    b_wr_data = {32'h77, 32'h19};
    b_bs_en   = 1'b1;
    b_bs_addr = 5'd25;
    step();
    b_wr_en   = 2'b00;
    b_bs_en   = 1'b0;
    b_rd_addr = {5'd19, 5'd25};
    #1;
    check("b_oob_read", {b_rd_busy[0], b_rd_data[31:0]}, 33'h0);
    check("b_r19", {31'h0, b_rd_busy[1], b_rd_data[63:32]}, 64'h19);

    b_bs_en   = 1'b1;
    b_bs_addr = 5'd8;
    step();
    b_bs_en   = 1'b0;
    b_rd_addr = {5'd0, 5'd8};
    #1;
    check("b_r8_busy", {31'h0, b_rd_busy[0], b_rd_data[31:0]}, {31'h0, 1'b1, 32'h0});
    b_wr_en   = 2'b01;
    b_wr_addr = {5'd0, 5'd8};
    b_wr_data = {32'h0, 32'h88};
    #1;
    check("b_r8_no_bypass_busy", {31'h0, b_rd_busy[0], b_rd_data[31:0]},
          {31'h0, 1'b1, 32'h0});
    step();
    b_wr_en = 2'b00;
    #1;
    check("b_r8_written", {31'h0, b_rd_busy[0], b_rd_data[31:0]}, {31'h0, 1'b0, 32'h88});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
